// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared types and sizes for the FFT job scheduler.
//   SchedState - scheduler FSM state encoding
//   N_BEATS    - beats per LOAD and per UNLOAD phase
//   BEAT_W     - beat counter width
//   SMP_W      - one sample width
//   GRP_W      - one sample group, {D3,D2,D1,D0}
package fft_sched_pkg;

    localparam int N_BEATS = 64;
    localparam int BEAT_W  = 6;
    localparam int SMP_W   = 64;
    localparam int GRP_W   = 4 * SMP_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        UNLOAD
    } SchedState;

endpackage

// File: rtl/fft_sched_if.sv
// fft_sched_if: requester, result and core-side signals of the FFT scheduler.
//   slave  - seen by the scheduler (requests, input groups and core results in;
//            grants, ready, results and core control out)
//   master - seen by the environment (the two requesters plus the FFT core)
interface fft_sched_if;
    import fft_sched_pkg::*;

    logic             req0;
    logic             req1;
    logic [GRP_W-1:0] din0;
    logic [GRP_W-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             irdy0;
    logic             irdy1;
    logic [GRP_W-1:0] dout;
    logic             ovld0;
    logic             ovld1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic             coreStart;
    logic [GRP_W-1:0] coreD;
    logic             coreDone;
    logic [GRP_W-1:0] coreQ;

    modport slave (
        input  req0, req1, din0, din1, coreDone, coreQ,
        output gnt0, gnt1, irdy0, irdy1, dout, ovld0, ovld1,
               done0, done1, busy, coreStart, coreD
    );

    modport master (
        output req0, req1, din0, din1, coreDone, coreQ,
        input  gnt0, gnt1, irdy0, irdy1, dout, ovld0, ovld1,
               done0, done1, busy, coreStart, coreD
    );

endinterface

// File: rtl/fft_sched_arb.sv
// rr_arb2: two-way round-robin pick, purely combinational.
//   req0_i, req1_i - request levels
//   last_i         - index served by the previous job
//   gntIdx_o       - index to grant (meaningful only when any_o is high)
//   any_o          - at least one request is pending
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gntIdx_o,
    output logic any_o
);

    // With both requesting, the one not served last wins; otherwise the
    // lone requester wins (req1_i alone selects index 1, req0_i alone 0).
    assign gntIdx_o = (req0_i && req1_i) ? ~last_i : req1_i;
    assign any_o    = req0_i | req1_i;

endmodule

// File: rtl/fft_sched.sv
// fft_sched: arbitrates two requesters onto one FFT core. A job streams 64
// input groups into the core (LOAD), waits for the core (RUN), then streams
// 64 result groups back to the granted requester (UNLOAD).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fft_sched_if.slave: requests/grants, input groups, result groups,
//           per-requester valid/done, busy and the core start/data/done/result
module fft_sched
    import fft_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fft_sched_if.slave   bus
);

    SchedState         stateQ, stateD;
    logic [BEAT_W-1:0] beatQ, beatD;
    logic              grantQ, grantD;
    logic              lastQ, lastD;
    logic [GRP_W-1:0]  doutQ, doutD;
    logic              ovld0Q, ovld0D, ovld1Q, ovld1D;
    logic              done0Q, done0D, done1Q, done1D;

    logic              arbIdx;
    logic              arbAny;
    logic              lastBeat;
    logic              loading;
    logic              unloading;
    logic              busy;

    rr_arb2 uArb (
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .last_i   (lastQ),
        .gntIdx_o (arbIdx),
        .any_o    (arbAny)
    );

    // LAST resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            beatQ  <= '0;
            grantQ <= 1'b0;
            lastQ  <= 1'b1;
            doutQ  <= '0;
            ovld0Q <= 1'b0;
            ovld1Q <= 1'b0;
            done0Q <= 1'b0;
            done1Q <= 1'b0;
        end else begin
            stateQ <= stateD;
            beatQ  <= beatD;
            grantQ <= grantD;
            lastQ  <= lastD;
            doutQ  <= doutD;
            ovld0Q <= ovld0D;
            ovld1Q <= ovld1D;
            done0Q <= done0D;
            done1Q <= done1D;
        end
    end

    assign lastBeat  = (beatQ == LAST_BEAT);
    assign loading   = (stateQ == LOAD);
    assign unloading = (stateQ == UNLOAD);
    assign busy      = (stateQ != IDLE);

    // The beat counter is cleared on every state change and only advances in
    // LOAD and UNLOAD; CORE_DONE is looked at only in RUN.
    always_comb begin
        stateD = stateQ;
        beatD  = beatQ;
        grantD = grantQ;
        lastD  = lastQ;
        unique case (stateQ)
            IDLE: begin
                if (arbAny) begin
                    stateD = LOAD;
                    beatD  = '0;
                    grantD = arbIdx;
                    lastD  = arbIdx;
                end
            end
            LOAD: begin
                if (lastBeat) begin
                    stateD = RUN;
                    beatD  = '0;
                end else begin
                    beatD  = beatQ + 1'b1;
                end
            end
            RUN: begin
                if (bus.coreDone) begin
                    stateD = UNLOAD;
                    beatD  = '0;
                end
            end
            UNLOAD: begin
                if (lastBeat) begin
                    stateD = IDLE;
                    beatD  = '0;
                end else begin
                    beatD  = beatQ + 1'b1;
                end
            end
            default: begin
                stateD = IDLE;
                beatD  = '0;
            end
        endcase
    end

    // Result path is one register stage behind UNLOAD, so the final beat and
    // DONE land in the first IDLE cycle, exactly when GNT falls.
    always_comb begin
        doutD  = unloading ? bus.coreQ : '0;
        ovld0D = unloading && !grantQ;
        ovld1D = unloading &&  grantQ;
        done0D = ovld0D && lastBeat;
        done1D = ovld1D && lastBeat;
    end

    assign bus.busy      = busy;
    assign bus.gnt0      = busy && !grantQ;
    assign bus.gnt1      = busy &&  grantQ;
    assign bus.irdy0     = loading && !grantQ;
    assign bus.irdy1     = loading &&  grantQ;
    assign bus.coreStart = loading && (beatQ == '0);
    assign bus.coreD     = loading ? (grantQ ? bus.din1 : bus.din0) : '0;
    assign bus.dout      = doutQ;
    assign bus.ovld0     = ovld0Q;
    assign bus.ovld1     = ovld1Q;
    assign bus.done0     = done0Q;
    assign bus.done1     = done1Q;

endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: self-checking bench for fft_sched. The bench plays both
// requesters and the FFT core. Expected outputs come from a job timeline
// model: a job granted at cycle 0 loads on cycles 0..63, runs until the
// core-done cycle 64+d, unloads on 65+d..128+d and shows results one cycle
// later, with DONE on 129+d. Arbitration is modelled as plain round-robin.
module tb_fft_sched;

    logic clk;
    logic rst_n;

    fft_sched_if bus ();

    fft_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;
    int modelLast  = 1;
    bit curReq0    = 1'b0;
    bit curReq1    = 1'b0;

    logic         eGnt0, eGnt1, eIrdy0, eIrdy1, eBusy, eStart;
    logic         eOvld0, eOvld1, eDone0, eDone1;
    logic [255:0] eCoreD, eDout;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    function automatic int modelPick(bit r0, bit r1, int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [255:0] d0, input logic [255:0] d1,
                                 input logic cd, input logic [255:0] cq);
        bus.req0     = r0;
        bus.req1     = r1;
        bus.din0     = d0;
        bus.din1     = d1;
        bus.coreDone = cd;
        bus.coreQ    = cq;
    endtask

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    endtask

    task automatic expectQuiet();
        eGnt0 = 0; eGnt1 = 0; eIrdy0 = 0; eIrdy1 = 0; eBusy = 0; eStart = 0;
        eOvld0 = 0; eOvld1 = 0; eDone0 = 0; eDone1 = 0; eCoreD = '0; eDout = '0;
    endtask

    task automatic checkAll(input int cyc);
        checkOutput("gnt0",      cyc, 256'(bus.gnt0),      256'(eGnt0));
        checkOutput("gnt1",      cyc, 256'(bus.gnt1),      256'(eGnt1));
        checkOutput("irdy0",     cyc, 256'(bus.irdy0),     256'(eIrdy0));
        checkOutput("irdy1",     cyc, 256'(bus.irdy1),     256'(eIrdy1));
        checkOutput("busy",      cyc, 256'(bus.busy),      256'(eBusy));
        checkOutput("coreStart", cyc, 256'(bus.coreStart), 256'(eStart));
        checkOutput("coreD",     cyc, bus.coreD,           eCoreD);
        checkOutput("ovld0",     cyc, 256'(bus.ovld0),     256'(eOvld0));
        checkOutput("ovld1",     cyc, 256'(bus.ovld1),     256'(eOvld1));
        checkOutput("done0",     cyc, 256'(bus.done0),     256'(eDone0));
        checkOutput("done1",     cyc, 256'(bus.done1),     256'(eDone1));
        checkOutput("dout",      cyc, bus.dout,            eDout);
    endtask

    // One idle cycle that sets the request levels seen by the next arbitration.
    task automatic idleCycle(input bit r0, input bit r1);
        tick();
        curReq0 = r0;
        curReq1 = r1;
        applyStimulus(r0, r1, rand256(), rand256(), 1'($urandom_range(0, 1)), rand256());
        #1;
        expectQuiet();
        checkAll(-1);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        curReq0 = 0;
        curReq1 = 0;
        modelLast = 1;
        applyStimulus(0, 0, '0, '0, 0, '0);
        #1;
        expectQuiet();
        checkAll(-2);
        tick();
        checkAll(-3);
        rst_n = 1'b1;
    endtask

    // Runs one job whose arbitration happens at the edge ending the current
    // cycle. Negative beat arguments disable the optional event.
    task automatic runJob(input int runDelay, input int spuriousBeat, input int dropBeat,
                          input int abortBeat, input bit rampData,
                          input bit nextReq0, input bit nextReq1);
        int           idx;
        int           uk;
        int           ok;
        logic [255:0] q [64];
        logic [255:0] d0, d1, cq;
        logic         cd;
        bit           inLoad;
        idx = modelPick(curReq0, curReq1, modelLast);
        modelLast = idx;
        $display("[TB] job for requester %0d, run delay %0d", idx, runDelay);
        for (int k = 0; k < 64; k++) q[k] = rampData ? ~256'(k) : rand256();
        for (int c = 0; c <= 129 + runDelay; c++) begin
            tick();
            uk = c - (65 + runDelay);
            ok = c - (66 + runDelay);
            d0 = rampData ? 256'(c) : rand256();
            d1 = rand256();
            cq = rand256();
            cd = 1'b0;
            if (c == spuriousBeat) cd = 1'b1;
            if (c == 64 + runDelay) cd = 1'b1;
            if (uk >= 0 && uk <= 63) begin
                cq = q[uk];
                cd = 1'($urandom_range(0, 1));
            end
            if (c == dropBeat) begin
                if (idx == 0) curReq0 = 0;
                else          curReq1 = 0;
            end
            if (c == 129 + runDelay) begin
                curReq0 = nextReq0;
                curReq1 = nextReq1;
            end
            applyStimulus(curReq0, curReq1, d0, d1, cd, cq);
            if (abortBeat >= 0 && uk == abortBeat) begin
                resetPulse();
                return;
            end
            #1;
            inLoad = (c <= 63);
            eBusy  = (c <= 128 + runDelay);
            eGnt0  = eBusy && idx == 0;
            eGnt1  = eBusy && idx == 1;
            eIrdy0 = inLoad && idx == 0;
            eIrdy1 = inLoad && idx == 1;
            eStart = (c == 0);
            eCoreD = inLoad ? ((idx == 1) ? d1 : d0) : '0;
            eOvld0 = (ok >= 0 && ok <= 63) && idx == 0;
            eOvld1 = (ok >= 0 && ok <= 63) && idx == 1;
            eDone0 = (ok == 63) && idx == 0;
            eDone1 = (ok == 63) && idx == 1;
            eDout  = (ok >= 0 && ok <= 63) ? q[ok] : '0;
            checkAll(c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, '0);
        #12;
        expectQuiet();
        checkAll(-4);
        tick();
        rst_n = 1'b1;

        $display("[TB] single job, ramp data");
        idleCycle(1, 0);
        runJob(10, -1, -1, -1, 1'b1, 0, 0);

        $display("[TB] contention from reset and fairness over four jobs");
        tick();
        resetPulse();
        idleCycle(1, 1);
        runJob($urandom_range(0, 12), -1, -1, -1, 1'b0, 1, 1);
        runJob($urandom_range(0, 12), -1, -1, -1, 1'b0, 1, 1);
        runJob($urandom_range(0, 12), 20, -1, -1, 1'b0, 1, 1);
        runJob($urandom_range(0, 12), -1, -1, -1, 1'b0, 0, 0);

        $display("[TB] request dropped during LOAD");
        idleCycle(0, 1);
        runJob($urandom_range(0, 12), -1, 5, -1, 1'b0, 0, 0);

        $display("[TB] reset during UNLOAD, then a fresh job");
        idleCycle(1, 0);
        runJob($urandom_range(0, 12), -1, -1, 30, 1'b0, 0, 0);
        idleCycle(0, 1);
        runJob($urandom_range(0, 12), 20, -1, -1, 1'b0, 0, 0);
        idleCycle(0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RSTn  input  1  asynchronous, active-low reset.
REQ-003 REQ0 / REQ1  input  1 each  job request from requester 0 / 1; level, held until granted.
REQ-004 DIN0 / DIN1  input  256 each  requester input sample group; {D3,D2,D1,D0}, 64 b each.
REQ-005 GNT0 / GNT1  output  1 each  grant; high from entry to LOAD through last UNLOAD beat.
REQ-006 IRDY0 / IRDY1  output  1 each  granted requester must drive a new DIN group this cycle.
REQ-007 DOUT  output  256  result sample group, broadcast to both requesters.
REQ-008 OVLD0 / OVLD1  output  1 each  DOUT valid for requester 0 / 1.
REQ-009 DONE0 / DONE1  output  1 each  one-cycle pulse coincident with the last OVLD beat.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 CORE_START  output  1  one-cycle start pulse to the FFT core.
REQ-012 CORE_D  output  256  input group to core.
REQ-013 CORE_DONE  input  1  core completion pulse.
REQ-014 CORE_Q  input  256  core output group, valid on the 64 cycles after CORE_DONE.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and UNLOAD.
REQ-016 IDLE SHALL move to LOAD when either REQ is high; with both high, it SHALL grant the requester not served last (LAST pointer).
REQ-017 In the first LOAD cycle, CORE_START SHALL be 1 for exactly one cycle.
REQ-018 LOAD SHALL last exactly 64 cycles, counted by a 6-bit beat counter from 0 to 63; it SHALL exit to RUN at count 63.
REQ-019 In LOAD, CORE_D SHALL equal DIN of the granted requester (combinational), and IRDY of the granted requester SHALL be 1; the other IRDY SHALL be 0.
REQ-020 Outside LOAD, CORE_D SHALL be 0.
REQ-021 RUN SHALL wait without limit for CORE_DONE, then go to UNLOAD.
REQ-022 CORE_DONE in IDLE, LOAD or UNLOAD SHALL be ignored.
REQ-023 UNLOAD SHALL last exactly 64 cycles, counted 0..63, then return to IDLE.
REQ-024 In UNLOAD, CORE_Q SHALL be registered into DOUT, and OVLD of the granted requester SHALL be registered with it.
REQ-025 Latency: CORE_Q of UNLOAD beat k SHALL appear on DOUT one cycle later.
REQ-026 DONE SHALL pulse with OVLD beat 63; GNT SHALL drop in the same cycle.
REQ-027 LAST SHALL update to the granted index when entering LOAD.
REQ-028 REQ deassertion after grant SHALL be ignored; the job always completes.
REQ-029 After the last OVLD beat, IDLE SHALL be able to grant on the next cycle, giving a 1-cycle minimum gap between jobs.
REQ-030 The beat counter SHALL clear on every state entry and SHALL not wrap inside a state.

Reset
REQ-031 On RSTn low, the block SHALL go to IDLE and set counter=0 and LAST=1 (so requester 0 wins the first contention).
REQ-032 On RSTn low, every output SHALL be 0, including DOUT.
REQ-033 Reset mid-job SHALL abort without a DONE pulse; the core is reset by the same RSTn.

Structure
REQ-034 A shared package SHALL hold the state enum, N_BEATS=64, BEAT_W=6, GRP_W=256 and SMP_W=64.
REQ-035 The round-robin pick SHALL be one sub-module, rr_arb2 (REQ0, REQ1, LAST -> GNT index, any).
REQ-036 The rest SHALL be a single registered FSM with one counter and no memories.

Verification
REQ-037 Single job: REQ0=1, DIN0=beat index, CORE_DONE 10 cycles after LOAD ends, CORE_Q=~beat -> CORE_START one pulse; 64 IRDY0; 64 OVLD0 with DOUT=~k one cycle later; DONE0 with beat 63.
REQ-038 Contention from reset: REQ0=REQ1=1 -> job 0 first, job 1 granted exactly 1 cycle after DONE0; GNT0 and GNT1 never both high.
REQ-039 Fairness: REQ0 and REQ1 held high for 4 jobs -> grants alternate 0,1,0,1.
REQ-040 Spurious done: CORE_DONE pulsed in LOAD beat 20 -> ignored; RUN still waits for the real CORE_DONE.
REQ-041 Reset mid-UNLOAD: RSTn low at beat 30 -> all outputs 0 immediately, no DONE; the next REQ1 is granted normally.
REQ-042 REQ dropped: REQ1 deasserted in LOAD beat 5 -> all 64 LOAD and 64 UNLOAD beats complete, and DONE1 pulses.
